// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if
// Bundles the two requester handshakes (CPU load/store path = master 0,
// debug/loader port = master 1) together with the shared peripheral
// register bus.
//
// Signals:
//   mN_req/mN_we/mN_addr/mN_wd  request side of master N (held until mN_ack)
//   mN_ack/mN_err/mN_rd         one-cycle completion pulse, error flag, read data
//   A/WD/WE                     peripheral address, write data, write strobe
//   RD                          peripheral read data (combinational from A)
//
// Modports:
//   slave  - the arbiter's view (consumes requests, drives acks and the bus)
//   master - the requesters/peripheral view (drives requests and RD)
interface periph_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [4:0]  m0_addr;
  logic [31:0] m0_wd;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rd;

  logic        m1_req;
  logic        m1_we;
  logic [4:0]  m1_addr;
  logic [31:0] m1_wd;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rd;

  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    output m0_ack, m0_err, m0_rd,
    input  m1_req, m1_we, m1_addr, m1_wd,
    output m1_ack, m1_err, m1_rd,
    output A, WD, WE,
    input  RD
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    input  m0_ack, m0_err, m0_rd,
    output m1_req, m1_we, m1_addr, m1_wd,
    input  m1_ack, m1_err, m1_rd,
    input  A, WD, WE,
    output RD
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Two-master arbiter and sequencer for the peripheral register window.
// Each transaction takes IDLE -> ACCESS -> RESP: the winner's request is
// latched in IDLE, the shared bus is driven for exactly one ACCESS cycle,
// and the winner gets a one-cycle ack (with read data / error) in RESP.
// Undecoded addresses never raise WE and return err=1, rd=0.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin on ties, 1 = master 0 always wins ties
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    periph_bus_arbiter_if.slave (both masters + peripheral bus)
module periph_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  periph_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_id;
  logic        r_we;
  logic        r_err;
  logic        r_lastGrant;
  logic [4:0]  r_busA;
  logic [31:0] r_busWd;
  logic        r_busWe;
  logic        r_m0Ack;
  logic        r_m0Err;
  logic [31:0] r_m0Rd;
  logic        r_m1Ack;
  logic        r_m1Err;
  logic [31:0] r_m1Rd;

  logic        w_anyReq;
  logic        w_pick1;
  logic [4:0]  w_selAddr;
  logic [31:0] w_selWd;
  logic        w_selWe;
  logic        w_selErr;
  logic [31:0] w_rdCapture;

  // Master 1 wins when it is the only requester, or on a tie in round-robin
  // mode when master 0 held the last grant.
  assign w_anyReq  = bus.m0_req | bus.m1_req;
  assign w_pick1   = bus.m1_req & (~bus.m0_req | (!FIXED_PRIO && !r_lastGrant));
  assign w_selAddr = w_pick1 ? bus.m1_addr : bus.m0_addr;
  assign w_selWd   = w_pick1 ? bus.m1_wd   : bus.m0_wd;
  assign w_selWe   = w_pick1 ? bus.m1_we   : bus.m0_we;

  // Decoded registers are the word-aligned addresses 0..24; 28 and every
  // unaligned address are holes in the window.
  assign w_selErr  = !((w_selAddr[1:0] == 2'b00) && (w_selAddr[4:2] != 3'b111));

  // Writes and errored accesses return zero so stale bus data never leaks.
  assign w_rdCapture = (r_err || r_we) ? 32'd0 : bus.RD;

  // Sequencer: all bus and ack outputs are registered here, so no request
  // input reaches A/WD/WE/ack combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_lastGrant <= 1'b1;
      r_busA      <= 5'd0;
      r_busWd     <= 32'd0;
      r_busWe     <= 1'b0;
      r_m0Ack     <= 1'b0;
      r_m0Err     <= 1'b0;
      r_m0Rd      <= 32'd0;
      r_m1Ack     <= 1'b0;
      r_m1Err     <= 1'b0;
      r_m1Rd      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_id    <= w_pick1;
            r_we    <= w_selWe;
            r_err   <= w_selErr;
            r_busA  <= w_selAddr;
            r_busWd <= w_selWd;
            r_busWe <= w_selWe & ~w_selErr;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // RD is sampled at the end of the single cycle A is on the bus.
          r_busA  <= 5'd0;
          r_busWd <= 32'd0;
          r_busWe <= 1'b0;
          if (r_id) begin
            r_m1Ack <= 1'b1;
            r_m1Err <= r_err;
            r_m1Rd  <= w_rdCapture;
          end else begin
            r_m0Ack <= 1'b1;
            r_m0Err <= r_err;
            r_m0Rd  <= w_rdCapture;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_m0Ack     <= 1'b0;
          r_m0Err     <= 1'b0;
          r_m0Rd      <= 32'd0;
          r_m1Ack     <= 1'b0;
          r_m1Err     <= 1'b0;
          r_m1Rd      <= 32'd0;
          r_lastGrant <= r_id;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.A      = r_busA;
  assign bus.WD     = r_busWd;
  assign bus.WE     = r_busWe;
  assign bus.m0_ack = r_m0Ack;
  assign bus.m0_err = r_m0Err;
  assign bus.m0_rd  = r_m0Rd;
  assign bus.m1_ack = r_m1Ack;
  assign bus.m1_err = r_m1Err;
  assign bus.m1_rd  = r_m1Rd;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter
// Drives a round-robin arbiter (dut0) and a fixed-priority arbiter (dut1).
// Expected acks and bus writes are queued when each request is driven and
// popped by a negedge monitor whenever an arbiter acks or raises WE.
module tb_periph_bus_arbiter;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rd;
  } respT;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wd;
  } wrT;

  logic clk = 1'b0;
  logic reset0;
  logic reset1;

  int compareCount = 0;
  int failCount = 0;

  respT respQ0[$];
  respT respQ1[$];
  wrT   wrQ0[$];
  wrT   wrQ1[$];

  periph_bus_arbiter_if bus0();
  periph_bus_arbiter_if bus1();

  periph_bus_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
    .clk(clk),
    .reset(reset0),
    .bus(bus0)
  );

  periph_bus_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
    .clk(clk),
    .reset(reset1),
    .bus(bus1)
  );

  always #5 clk = ~clk;

  // Peripheral stub: register 8 holds 0x12345678, others an address pattern.
  function automatic logic [31:0] rdModel(input logic [4:0] addr);
    if (addr == 5'd8) return 32'h12345678;
    return 32'hA5A50000 | (32'(addr) * 32'h101);
  endfunction

  function automatic bit isDecoded(input logic [4:0] addr);
    return ((int'(addr) % 4) == 0) && (int'(addr) <= 24);
  endfunction

  assign bus0.RD = rdModel(bus0.A);
  assign bus1.RD = rdModel(bus1.A);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input int sel, input bit id, input logic we,
                            input logic [4:0] addr, input logic [31:0] wd);
    respT r;
    wrT   w;
    r.id  = id;
    r.err = !isDecoded(addr);
    r.rd  = (r.err || we) ? 32'd0 : rdModel(addr);
    w.addr = addr;
    w.wd   = wd;
    if (sel == 0) begin
      respQ0.push_back(r);
      if (we && !r.err) wrQ0.push_back(w);
    end else begin
      respQ1.push_back(r);
      if (we && !r.err) wrQ1.push_back(w);
    end
  endtask

  task automatic driveReq(input int sel, input int m, input logic we,
                          input logic [4:0] addr, input logic [31:0] wd);
    if (sel == 0 && m == 0) begin
      bus0.m0_we = we; bus0.m0_addr = addr; bus0.m0_wd = wd; bus0.m0_req = 1'b1;
    end else if (sel == 0) begin
      bus0.m1_we = we; bus0.m1_addr = addr; bus0.m1_wd = wd; bus0.m1_req = 1'b1;
    end else if (m == 0) begin
      bus1.m0_we = we; bus1.m0_addr = addr; bus1.m0_wd = wd; bus1.m0_req = 1'b1;
    end else begin
      bus1.m1_we = we; bus1.m1_addr = addr; bus1.m1_wd = wd; bus1.m1_req = 1'b1;
    end
  endtask

  task automatic dropReq(input int sel, input int m);
    if (sel == 0 && m == 0)      bus0.m0_req = 1'b0;
    else if (sel == 0)           bus0.m1_req = 1'b0;
    else if (m == 0)             bus1.m0_req = 1'b0;
    else                         bus1.m1_req = 1'b0;
  endtask

  function automatic logic getAck(input int sel, input int m);
    if (sel == 0) return (m == 0) ? bus0.m0_ack : bus0.m1_ack;
    return (m == 0) ? bus1.m0_ack : bus1.m1_ack;
  endfunction

  // Counts rising edges until the ack is seen #1 after an edge; bounded.
  task automatic waitAck(input int sel, input int m, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (getAck(sel, m) !== 1'b1 && cycles < 20);
    if (getAck(sel, m) !== 1'b1) checkOutput("ack timeout", 32'(cycles), 32'd0);
  endtask

  // One isolated transaction, started in an IDLE cycle; ends in the next IDLE.
  task automatic applyStimulus(input int sel, input int m, input logic we,
                               input logic [4:0] addr, input logic [31:0] wd);
    int cycles;
    pushExpect(sel, m[0], we, addr, wd);
    driveReq(sel, m, we, addr, wd);
    waitAck(sel, m, cycles);
    checkOutput("latency", 32'(cycles), 32'd2);
    dropReq(sel, m);
    @(posedge clk);
    #1;
  endtask

  task automatic monitorDut(input int sel);
    logic        we, a0, a1, e0, e1;
    logic [4:0]  addr;
    logic [31:0] wdata, rd0, rd1;
    respT r;
    wrT   w;
    if (sel == 0) begin
      we = bus0.WE; addr = bus0.A; wdata = bus0.WD;
      a0 = bus0.m0_ack; a1 = bus0.m1_ack; e0 = bus0.m0_err; e1 = bus0.m1_err;
      rd0 = bus0.m0_rd; rd1 = bus0.m1_rd;
    end else begin
      we = bus1.WE; addr = bus1.A; wdata = bus1.WD;
      a0 = bus1.m0_ack; a1 = bus1.m1_ack; e0 = bus1.m0_err; e1 = bus1.m1_err;
      rd0 = bus1.m0_rd; rd1 = bus1.m1_rd;
    end
    if (we === 1'b1) begin
      if ((sel == 0 ? wrQ0.size() : wrQ1.size()) == 0) begin
        checkOutput("unexpected WE", 32'd1, 32'd0);
      end else begin
        w = (sel == 0) ? wrQ0.pop_front() : wrQ1.pop_front();
        checkOutput("WE addr", 32'(addr), 32'(w.addr));
        checkOutput("WE data", wdata, w.wd);
      end
    end
    if (a0 === 1'b1 || a1 === 1'b1) begin
      if ((sel == 0 ? respQ0.size() : respQ1.size()) == 0) begin
        checkOutput("unexpected ack", {30'd0, a1, a0}, 32'd0);
      end else begin
        r = (sel == 0) ? respQ0.pop_front() : respQ1.pop_front();
        checkOutput("ack grant", {30'd0, a1, a0}, r.id ? 32'd2 : 32'd1);
        checkOutput("ack err", {31'd0, r.id ? e1 : e0}, {31'd0, r.err});
        checkOutput("ack rd", r.id ? rd1 : rd0, r.rd);
        checkOutput("idle master rd", r.id ? rd0 : rd1, 32'd0);
        checkOutput("idle master err", {31'd0, r.id ? e0 : e1}, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    monitorDut(0);
    monitorDut(1);
  end

  initial begin
    int cycles;
    reset0 = 1'b1;
    reset1 = 1'b1;
    bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = 0; bus0.m0_wd = 0;
    bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = 0; bus0.m1_wd = 0;
    bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wd = 0;
    bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wd = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset values");
    checkOutput("reset A", 32'(bus0.A), 32'd0);
    checkOutput("reset WD", bus0.WD, 32'd0);
    checkOutput("reset WE", {31'd0, bus0.WE}, 32'd0);
    checkOutput("reset acks", {30'd0, bus0.m1_ack, bus0.m0_ack}, 32'd0);
    checkOutput("reset errs", {30'd0, bus0.m1_err, bus0.m0_err}, 32'd0);
    checkOutput("reset m0_rd", bus0.m0_rd, 32'd0);
    checkOutput("reset m1_rd", bus0.m1_rd, 32'd0);
    checkOutput("reset dut1 WE/acks", {29'd0, bus1.WE, bus1.m1_ack, bus1.m0_ack}, 32'd0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single write, single read, undecoded accesses");
    pushExpect(0, 1'b0, 1'b1, 5'd4, 32'h000A5);
    driveReq(0, 0, 1'b1, 5'd4, 32'h000A5);
    @(posedge clk);
    #1;
    checkOutput("write WE in ACCESS", {31'd0, bus0.WE}, 32'd1);
    checkOutput("write ack not early", {31'd0, bus0.m0_ack}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("write ack", {31'd0, bus0.m0_ack}, 32'd1);
    checkOutput("write WE dropped", {31'd0, bus0.WE}, 32'd0);
    dropReq(0, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 1'b0, 5'd8, 32'd0);
    applyStimulus(0, 0, 1'b1, 5'd5, 32'hFFFFFFFF);
    applyStimulus(0, 1, 1'b0, 5'd28, 32'd0);
    applyStimulus(0, 1, 1'b1, 5'd24, 32'hDEADBEEF);

    $display("[TB] round-robin contention");
    reset0 = 1'b1;
    @(posedge clk);
    #1;
    reset0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pushExpect(0, 1'b0, 1'b0, 5'd12, 32'd0);
      pushExpect(0, 1'b1, 1'b1, 5'd16, 32'h55);
    end
    driveReq(0, 0, 1'b0, 5'd12, 32'd0);
    driveReq(0, 1, 1'b1, 5'd16, 32'h55);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("rr fourth ack is m1", {30'd0, bus0.m1_ack, bus0.m0_ack}, 32'd2);
    dropReq(0, 0);
    dropReq(0, 1);
    @(posedge clk);
    #1;

    $display("[TB] late request and request change during ACCESS");
    pushExpect(0, 1'b0, 1'b0, 5'd0, 32'd0);
    pushExpect(0, 1'b1, 1'b0, 5'd4, 32'd0);
    driveReq(0, 0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    bus0.m0_addr = 5'd28;
    bus0.m0_we = 1'b1;
    bus0.m0_wd = 32'h13579BDF;
    driveReq(0, 1, 1'b0, 5'd4, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("late m0 ack", {30'd0, bus0.m1_ack, bus0.m0_ack}, 32'd1);
    dropReq(0, 0);
    waitAck(0, 1, cycles);
    checkOutput("late m1 ack spacing", 32'(cycles), 32'd3);
    dropReq(0, 1);
    @(posedge clk);
    #1;

    $display("[TB] reset during ACCESS");
    applyStimulus(0, 0, 1'b0, 5'd20, 32'd0);
    wrQ0.push_back('{addr: 5'd20, wd: 32'h77});
    driveReq(0, 1, 1'b1, 5'd20, 32'h77);
    @(posedge clk);
    #1;
    checkOutput("pre-reset WE", {31'd0, bus0.WE}, 32'd1);
    reset0 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset WE", {31'd0, bus0.WE}, 32'd0);
    checkOutput("post-reset no m1 ack", {31'd0, bus0.m1_ack}, 32'd0);
    reset0 = 1'b0;
    pushExpect(0, 1'b0, 1'b0, 5'd12, 32'd0);
    pushExpect(0, 1'b1, 1'b0, 5'd8, 32'd0);
    driveReq(0, 0, 1'b0, 5'd12, 32'd0);
    driveReq(0, 1, 1'b0, 5'd8, 32'd0);
    waitAck(0, 0, cycles);
    checkOutput("post-reset m0 first", 32'(cycles), 32'd2);
    dropReq(0, 0);
    waitAck(0, 1, cycles);
    checkOutput("post-reset m1 second", 32'(cycles), 32'd3);
    dropReq(0, 1);
    @(posedge clk);
    #1;

    $display("[TB] fixed priority starvation");
    for (int k = 0; k < 4; k++) pushExpect(1, 1'b0, 1'b0, 5'd4, 32'd0);
    pushExpect(1, 1'b1, 1'b0, 5'd8, 32'd0);
    driveReq(1, 0, 1'b0, 5'd4, 32'd0);
    driveReq(1, 1, 1'b0, 5'd8, 32'd0);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("fp fourth ack is m0", {30'd0, bus1.m1_ack, bus1.m0_ack}, 32'd1);
    dropReq(1, 0);
    waitAck(1, 1, cycles);
    checkOutput("fp m1 after m0 drops", 32'(cycles), 32'd3);
    dropReq(1, 1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("dut0 acks outstanding", 32'(respQ0.size()), 32'd0);
    checkOutput("dut1 acks outstanding", 32'(respQ1.size()), 32'd0);
    checkOutput("dut0 writes outstanding", 32'(wrQ0.size()), 32'd0);
    checkOutput("dut1 writes outstanding", 32'(wrQ1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
